adc0808_scan_sequencer: RTL and testbench
=========================================

// Module: adc0808_scan_sequencer
// PURPOSE
//  Parametrised multi-channel ADC0808 sequencer. Generates the ADC clock, ALE, START and OE.
//  Drives the mux address and scans the enabled channels round-robin.
//  Averages 2^AVG_LOG2 conversions per channel and emits one tagged result per channel visit.
//  Sits between the Pmod ADC pins and the BCD/7-seg display path.
// PARAMETERS
//  DATA_W       8     ADC data width
//  NUM_CH       8     number of analog channels
//  CH_W         3     address width, clog2(NUM_CH)
//  ADC_HALF     1000  clk cycles per adc_clk half-period (100MHz -> 50kHz)
//  T_PULSE      10    clk cycles for the setup, strobe and OE phases (>=1)
//  AVG_LOG2     2     log2 of conversions averaged per result (0 = no averaging)
//  TIMEOUT      2^20  clk cycles allowed in each EOC wait state
// PORTS
//  clk           in   1        system clock (100MHz)
//  reset_n       in   1        asynchronous, active-low reset
//  enable        in   1        run scanning
//  ch_mask       in   NUM_CH   bit i=1 -> channel i is scanned
//  clear_err     in   1        clears timeout_err
//  adc_eoc       in   1        ADC end-of-conversion, asynchronous
//  adc_data      in   DATA_W   ADC data bus
//  adc_clk       out  1        ADC conversion clock
//  adc_addr      out  CH_W     ADC mux address
//  adc_ale       out  1        address latch enable
//  adc_start     out  1        start conversion
//  adc_oe        out  1        output enable
//  sample_valid  out  1        1-cycle pulse: result available
//  sample_ch     out  CH_W     channel of the result
//  sample_data   out  DATA_W   averaged result
//  busy          out  1        FSM not in IDLE
//  timeout_err   out  1        sticky EOC timeout flag
// BEHAVIOUR
//  - Reset: every output is 0; FSM in IDLE; cur_ch=0; accumulator, counters and divider are 0.
//  - adc_clk: free-running divider. It toggles every ADC_HALF clk cycles, independent of enable.
//  - adc_eoc is passed through a 2-FF synchronizer (2-cycle latency) before the FSM uses it.
//  - FSM:
//    IDLE -> SETUP when enable=1 and ch_mask!=0. cur_ch = lowest set bit at or above cur_ch, with wrap.
//    SETUP: adc_addr=cur_ch, all strobes low, T_PULSE cycles -> STROBE.
//    STROBE: adc_ale=adc_start=1 for T_PULSE cycles -> WAIT_LO.
//    WAIT_LO: wait for eoc_s==0 -> WAIT_HI.
//    WAIT_HI: wait for eoc_s==1 -> READ.
//    READ: adc_oe=1 for T_PULSE cycles. adc_data is captured on the last OE cycle -> ACC.
//    ACC: acc += data; n++.
//      If n==2^AVG_LOG2: go to NEXT. Otherwise go to SETUP with the same channel.
//    NEXT: sample_valid=1 for exactly this cycle.
//      sample_data = acc>>AVG_LOG2 (truncating); sample_ch = cur_ch.
//      Clear acc and n. cur_ch = next set mask bit above cur_ch, wrapping to the lowest.
//      Then -> SETUP if enable=1 and mask!=0, else IDLE.
//  - adc_addr is held stable from SETUP through READ. It changes only in NEXT or IDLE.
//  - acc width is DATA_W+AVG_LOG2 and cannot overflow. An all-ones input averages to all-ones.
//  - sample_ch/sample_data hold their values until the next NEXT.
//  - ch_mask is sampled only in IDLE and NEXT. Mid-conversion mask changes do not abort.
//  - A single-bit mask re-selects the same channel every visit.
//  - enable low mid-conversion: finish the current conversion through ACC.
//    Then discard the partial average (no sample_valid) and go to IDLE.
//    Exception: if ACC completes the average, NEXT still emits it.
//  - Timeout: a counter restarts on entry to WAIT_LO and again on entry to WAIT_HI.
//    If it reaches TIMEOUT: set timeout_err, discard acc/n, no sample_valid.
//    Advance the channel as in NEXT (without the pulse), then continue.
//  - clear_err: clears timeout_err on the next cycle.
//    If a timeout occurs in the same cycle as clear_err, the set wins.
//  - Asserting reset_n low at any point aborts immediately to reset values. ADC pins go low.
// TESTING
//  - Reset: hold reset_n=0 mid-STROBE -> all outputs 0 immediately.
//    Release -> IDLE, busy=0, adc_clk begins toggling every ADC_HALF cycles.
//  - ADC model returns 8'h80, 8'h81, 8'h82, 8'h83 on ch 2 (AVG_LOG2=2, mask=8'h04).
//    -> one sample_valid, ch=2, data=8'h81. ale/start/oe each high for exactly T_PULSE cycles.
//  - mask=8'b1000_0101 with a constant model value per channel
//    -> results ordered ch0, ch2, ch7, ch0 ...; adc_addr never changes between SETUP and READ.
//  - Model holds EOC high permanently (TIMEOUT=64)
//    -> timeout_err=1, no sample_valid, scanning moves to the next channel.
//    clear_err -> timeout_err=0 one cycle later.
//  - Model returns 8'hFF on every conversion -> sample_data=8'hFF (no overflow).
//    With AVG_LOG2=0 -> one sample_valid per conversion.
//  - Drop enable during WAIT_HI of the 2nd of 4 conversions
//    -> the conversion completes, no sample_valid, IDLE, busy=0.
//    Re-enable -> a fresh 4-sample average.

Source files
------------

// File: rtl/adc0808_scan_sequencer.sv
// adc0808_scan_sequencer: ADC0808 timing generator, round-robin channel scanner and per-channel averager
module adc0808_scan_sequencer #(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 8,
    parameter int CH_W     = 3,
    parameter int ADC_HALF = 1000,
    parameter int T_PULSE  = 10,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1 << 20
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              enable_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    input  logic              clear_err_i,
    input  logic              adc_eoc_i,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic              adc_clk_o,
    output logic [CH_W-1:0]   adc_addr_o,
    output logic              adc_ale_o,
    output logic              adc_start_o,
    output logic              adc_oe_o,
    output logic              sample_valid_o,
    output logic [CH_W-1:0]   sample_ch_o,
    output logic [DATA_W-1:0] sample_data_o,
    output logic              busy_o,
    output logic              timeout_err_o
);
    localparam int DW = $clog2(ADC_HALF + 1);
    localparam int PW = $clog2(T_PULSE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = DATA_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] N_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_LO, WAIT_HI, READ, ACC, NEXT} state_t;

    state_t              state_q;
    logic [DW-1:0]       div_q;
    logic [PW-1:0]       pcnt_q;
    logic [TW-1:0]       tcnt_q;
    logic [AVG_LOG2:0]   n_q;
    logic [AW-1:0]       acc_q;
    logic [AW-1:0]       sum_d;
    logic [DATA_W-1:0]   data_q;
    logic [CH_W-1:0]     ch_q;
    logic [CH_W-1:0]     sch_q;
    logic [DATA_W-1:0]   sdata_q;
    logic                eoc_m_q, eoc_s_q;
    logic                aclk_q, ale_q, start_q, oe_q, valid_q, err_q;
    logic                tout_d;
    logic                pend_d;
    logic                tlast_d;

    // off=0 selects the lowest set bit at or above c, off=1 strictly above c; both wrap
    function automatic logic [CH_W-1:0] pick(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] c,
                                             input int off);
        int idx;
        logic [CH_W-1:0] j;
        pick = c;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(c) + off + k) % NUM_CH;
            j = CH_W'(idx);
            if (m[j]) pick = j;
        end
    endfunction

    assign sum_d   = acc_q + AW'(data_q);
    assign tlast_d = tcnt_q == TW'(TIMEOUT - 1);
    assign tout_d  = tlast_d && ((state_q == WAIT_LO && eoc_s_q) || (state_q == WAIT_HI && !eoc_s_q));
    assign pend_d  = state_q == NEXT || tout_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            sch_q   <= '0;
            sdata_q <= '0;
            eoc_m_q <= 1'b0;
            eoc_s_q <= 1'b0;
            aclk_q  <= 1'b0;
            ale_q   <= 1'b0;
            start_q <= 1'b0;
            oe_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            eoc_m_q <= adc_eoc_i;
            eoc_s_q <= eoc_m_q;
            div_q   <= (div_q == DW'(ADC_HALF - 1)) ? '0 : div_q + 1'b1;
            if (div_q == DW'(ADC_HALF - 1)) aclk_q <= ~aclk_q;
            valid_q <= 1'b0;
            if (clear_err_i) err_q <= 1'b0;
            // a timeout abandons the visit exactly like NEXT, only without the result pulse
            if (pend_d) begin
                if (tout_d) err_q <= 1'b1;
                acc_q   <= '0;
                n_q     <= '0;
                pcnt_q  <= '0;
                ch_q    <= pick(ch_mask_i, ch_q, 1);
                state_q <= (enable_i && |ch_mask_i) ? SETUP : IDLE;
            end else begin
                case (state_q)
                    IDLE: if (enable_i && |ch_mask_i) begin
                        ch_q    <= pick(ch_mask_i, ch_q, 0);
                        pcnt_q  <= '0;
                        state_q <= SETUP;
                    end
                    SETUP: if (pcnt_q == PW'(T_PULSE - 1)) begin
                        pcnt_q  <= '0;
                        ale_q   <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= STROBE;
                    end else pcnt_q <= pcnt_q + 1'b1;
                    STROBE: if (pcnt_q == PW'(T_PULSE - 1)) begin
                        pcnt_q  <= '0;
                        tcnt_q  <= '0;
                        ale_q   <= 1'b0;
                        start_q <= 1'b0;
                        state_q <= WAIT_LO;
                    end else pcnt_q <= pcnt_q + 1'b1;
                    WAIT_LO: if (!eoc_s_q) begin
                        tcnt_q  <= '0;
                        state_q <= WAIT_HI;
                    end else tcnt_q <= tcnt_q + 1'b1;
                    WAIT_HI: if (eoc_s_q) begin
                        pcnt_q  <= '0;
                        oe_q    <= 1'b1;
                        state_q <= READ;
                    end else tcnt_q <= tcnt_q + 1'b1;
                    READ: if (pcnt_q == PW'(T_PULSE - 1)) begin
                        data_q  <= adc_data_i;
                        oe_q    <= 1'b0;
                        state_q <= ACC;
                    end else pcnt_q <= pcnt_q + 1'b1;
                    ACC: begin
                        acc_q <= sum_d;
                        n_q   <= n_q + 1'b1;
                        pcnt_q <= '0;
                        if (n_q == N_LAST) begin
                            sdata_q <= DATA_W'(sum_d >> AVG_LOG2);
                            sch_q   <= ch_q;
                            valid_q <= 1'b1;
                            state_q <= NEXT;
                        end else if (enable_i) state_q <= SETUP;
                        else begin
                            acc_q   <= '0;
                            n_q     <= '0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign adc_clk_o      = aclk_q;
    assign adc_addr_o     = ch_q;
    assign adc_ale_o      = ale_q;
    assign adc_start_o    = start_q;
    assign adc_oe_o       = oe_q;
    assign sample_valid_o = valid_q;
    assign sample_ch_o    = sch_q;
    assign sample_data_o  = sdata_q;
    assign busy_o         = state_q != IDLE;
    assign timeout_err_o  = err_q;
endmodule

// File: tb/tb_adc0808_scan_sequencer.sv
// tb_adc0808_scan_sequencer: directed bench with reactive ADC0808 models for an averaging and a non-averaging instance
module tb_adc0808_scan_sequencer;
    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       en_a = 1'b0, en_b = 1'b0, clr = 1'b0;
    logic [7:0] mask_a = '0, mask_b = '0;
    logic       eoc_a = 1'b1, eoc_b = 1'b1;
    logic [7:0] data_a = '0, data_b = '0;
    logic       aclk_a, ale_a, start_a, oe_a, sv_a, busy_a, err_a;
    logic       aclk_b, ale_b, start_b, oe_b, sv_b, busy_b, err_b;
    logic [2:0] addr_a, sch_a, addr_b, sch_b;
    logic [7:0] sd_a, sd_b;

    adc0808_scan_sequencer #(.DATA_W(8), .NUM_CH(8), .CH_W(3), .ADC_HALF(4), .T_PULSE(3),
                             .AVG_LOG2(2), .TIMEOUT(64)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(en_a), .ch_mask_i(mask_a), .clear_err_i(clr),
        .adc_eoc_i(eoc_a), .adc_data_i(data_a), .adc_clk_o(aclk_a), .adc_addr_o(addr_a),
        .adc_ale_o(ale_a), .adc_start_o(start_a), .adc_oe_o(oe_a), .sample_valid_o(sv_a),
        .sample_ch_o(sch_a), .sample_data_o(sd_a), .busy_o(busy_a), .timeout_err_o(err_a));

    adc0808_scan_sequencer #(.DATA_W(8), .NUM_CH(8), .CH_W(3), .ADC_HALF(4), .T_PULSE(3),
                             .AVG_LOG2(0), .TIMEOUT(64)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(en_b), .ch_mask_i(mask_b), .clear_err_i(clr),
        .adc_eoc_i(eoc_b), .adc_data_i(data_b), .adc_clk_o(aclk_b), .adc_addr_o(addr_b),
        .adc_ale_o(ale_b), .adc_start_o(start_b), .adc_oe_o(oe_b), .sample_valid_o(sv_b),
        .sample_ch_o(sch_b), .sample_data_o(sd_b), .busy_o(busy_b), .timeout_err_o(err_b));

    int checks = 0, failures = 0;
    int mcnt_a = 0, starts_a = 0, conv_a = 0, conv_base = 0, mcnt_b = 0, starts_b = 0;
    bit stuck = 1'b0, seq = 1'b0;
    logic st_prev_a = 1'b0, st_prev_b = 1'b0;
    logic [7:0] val [8];

    // EOC drops a few cycles after START rises and returns high with the data valid
    always @(negedge clk) begin
        if (start_a && !st_prev_a) begin
            starts_a++;
            mcnt_a = 1;
        end else if (mcnt_a != 0) begin
            mcnt_a++;
            if (mcnt_a == 5) eoc_a = 1'b0;
            if (mcnt_a == 12) begin
                eoc_a  = 1'b1;
                mcnt_a = 0;
                data_a = seq ? 8'h80 + 8'(conv_a - conv_base) : val[addr_a];
                conv_a++;
            end
        end
        if (stuck) begin
            eoc_a  = 1'b1;
            mcnt_a = 0;
        end
        st_prev_a = start_a;
    end

    always @(negedge clk) begin
        if (start_b && !st_prev_b) begin
            starts_b++;
            mcnt_b = 1;
        end else if (mcnt_b != 0) begin
            mcnt_b++;
            if (mcnt_b == 5) eoc_b = 1'b0;
            if (mcnt_b == 12) begin
                eoc_b  = 1'b1;
                mcnt_b = 0;
                data_b = 8'hFF;
            end
        end
        st_prev_b = start_b;
    end

    int ale_r = 0, st_r = 0, oe_r = 0, ale_w = 0, st_w = 0, oe_w = 0;
    int vcnt_a = 0, oes_a = 0, addr_err = 0;
    logic arm = 1'b0;
    logic [2:0] addr_l = '0;

    always @(negedge clk) begin
        if (!busy_a) arm = 1'b0;
        if (sv_a) vcnt_a++;
        if (ale_a) ale_r++;
        else if (ale_r != 0) begin ale_w = ale_r; ale_r = 0; end
        if (start_a) st_r++;
        else if (st_r != 0) begin st_w = st_r; st_r = 0; end
        if (oe_a) oe_r++;
        else if (oe_r != 0) begin oe_w = oe_r; oe_r = 0; oes_a++; arm = 1'b0; end
        if (ale_a && !arm) begin arm = 1'b1; addr_l = addr_a; end
        if (arm && addr_a !== addr_l) addr_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        en_a = 1'b0;
        en_b = 1'b0;
        reset_n = 1'b0;
        repeat (20) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_va(input string tag, input bit stop, output logic [2:0] ch, output logic [7:0] d);
        int i = 0;
        while (!sv_a && i < 2000) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(sv_a), 1);
        ch = sch_a;
        d  = sd_a;
        if (stop) en_a = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] ch;
        logic [7:0] d;
        logic       p;
        int c1, c2, v0, o0, s0, ae0, nb;
        int ech [4] = '{0, 2, 7, 0};
        int ed  [4] = '{'h10, 'h22, 'h7E, 'h10};
        val = '{default: 8'h00};
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        mask_a = 8'h04;
        en_a = 1'b1;
        for (int i = 0; i < 100 && !ale_a; i++) @(negedge clk);
        chk("t1_in_strobe", 32'(ale_a), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_reset_outs", 32'({aclk_a, addr_a, ale_a, start_a, oe_a, sv_a, sch_a, sd_a, busy_a, err_a}), 0);
        en_a = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("t1_busy_release", 32'(busy_a), 0);
        c1 = 0;
        p = aclk_a;
        for (int i = 0; i < 50 && aclk_a === p; i++) begin @(negedge clk); c1++; end
        c2 = 0;
        p = aclk_a;
        for (int i = 0; i < 50 && aclk_a === p; i++) begin @(negedge clk); c2++; end
        chk("t1_aclk_first", 32'(c1), 4);
        chk("t1_aclk_half", 32'(c2), 4);
        chk("t1_idle", 32'(busy_a), 0);

        do_reset();
        seq = 1'b1;
        conv_base = conv_a;
        v0 = vcnt_a;
        mask_a = 8'h04;
        en_a = 1'b1;
        wait_va("t2_valid", 1'b1, ch, d);
        chk("t2_ch", 32'(ch), 2);
        chk("t2_data", 32'(d), 'h81);
        chk("t2_ale_w", 32'(ale_w), 3);
        chk("t2_start_w", 32'(st_w), 3);
        chk("t2_oe_w", 32'(oe_w), 3);
        repeat (10) @(negedge clk);
        chk("t2_one_valid", 32'(vcnt_a - v0), 1);
        chk("t2_idle", 32'(busy_a), 0);

        do_reset();
        seq = 1'b0;
        val[0] = 8'h10;
        val[2] = 8'h22;
        val[7] = 8'h7E;
        ae0 = addr_err;
        mask_a = 8'h85;
        en_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_va($sformatf("t3_valid%0d", k), k == 3, ch, d);
            chk($sformatf("t3_ch%0d", k), 32'(ch), 32'(ech[k]));
            chk($sformatf("t3_data%0d", k), 32'(d), 32'(ed[k]));
        end
        chk("t3_addr_stable", 32'(addr_err - ae0), 0);

        do_reset();
        stuck = 1'b1;
        v0 = vcnt_a;
        mask_a = 8'h85;
        en_a = 1'b1;
        for (int i = 0; i < 500 && !err_a; i++) @(negedge clk);
        chk("t4_err_set", 32'(err_a), 1);
        chk("t4_next_ch", 32'(addr_a), 2);
        chk("t4_no_valid", 32'(vcnt_a - v0), 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t4_err_clear", 32'(err_a), 0);
        en_a = 1'b0;
        stuck = 1'b0;

        do_reset();
        val = '{default: 8'hFF};
        mask_a = 8'h04;
        en_a = 1'b1;
        wait_va("t5_valid", 1'b1, ch, d);
        chk("t5_ff_avg", 32'(d), 'hFF);
        mask_b = 8'h04;
        en_b = 1'b1;
        nb = 0;
        for (int i = 0; i < 3000 && nb < 3; i++) begin
            @(negedge clk);
            if (sv_b) begin
                nb++;
                chk($sformatf("t5b_data%0d", nb), 32'(sd_b), 'hFF);
            end
        end
        chk("t5b_valids", 32'(nb), 3);
        chk("t5b_one_per_conv", 32'(starts_b), 3);
        en_b = 1'b0;

        do_reset();
        seq = 1'b1;
        conv_base = conv_a;
        mask_a = 8'h04;
        v0 = vcnt_a;
        o0 = oes_a;
        s0 = starts_a;
        en_a = 1'b1;
        for (int i = 0; i < 500 && !(starts_a - s0 == 2 && !eoc_a); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        en_a = 1'b0;
        for (int i = 0; i < 500 && busy_a; i++) @(negedge clk);
        chk("t6_idle", 32'(busy_a), 0);
        chk("t6_conv_done", 32'(oes_a - o0), 2);
        chk("t6_no_valid", 32'(vcnt_a - v0), 0);
        en_a = 1'b1;
        wait_va("t6_valid", 1'b1, ch, d);
        chk("t6_ch", 32'(ch), 2);
        chk("t6_fresh_avg", 32'(d), 'h83);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
